// File: rtl/robbie_pkg.sv
// robbie_pkg: shared types and constants for the Robbie wheel drive.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t    - drive FSM state (IDLE / RAMP / RUN); 2'd3 is unused
//   WHEEL_FWD  - wheel action bit meaning "drive forward"
//   WHEEL_STOP - wheel action bit meaning "stop"
package robbie_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic WHEEL_FWD  = 1'b1;
  localparam logic WHEEL_STOP = 1'b0;

endpackage

// File: rtl/robbie_wheel_ramp.sv
// robbie_wheel_ramp: one wheel's duty register, step-toward-target logic and PWM compare.
// Latency: duty moves one count per step pulse; pwm is registered, one cycle behind the compare.
// Backpressure: none; step and clear are single-cycle strobes from the top-level FSM.
//
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   frame_cnt  - shared PWM frame position (0..PWM_PERIOD-1)
//   tgt        - duty this wheel is heading for
//   step       - move duty one count toward tgt this cycle
//   clear      - force duty to 0 immediately (illegal-state recovery)
//   duty       - current duty in cycles per frame
//   pwm        - registered motor drive, high while frame_cnt < duty
module robbie_wheel_ramp #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] frame_cnt,
  input  logic [W-1:0] tgt,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] duty,
  output logic         pwm
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      // duty 0 never beats the compare; duty PWM_PERIOD always does
      pwm <= (frame_cnt < duty);
      if (clear) begin
        duty <= '0;
      end else if (step) begin
        // single-count moves cannot overshoot the target
        if (duty < tgt) begin
          duty <= duty + W'(1);
        end else if (duty > tgt) begin
          duty <= duty - W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/robbie_wheel_drive.sv
// robbie_wheel_drive: two-wheel PWM drive with ramped duty changes and optional command watchdog.
// Latency: command accepted on the edge it is seen; duty steps every RAMP_STEP_CYCLES; pwm registered.
// Backpressure: cmd_ready low while ramping; commands offered then are dropped, not buffered.
//
// Optional feature: define ROBBIE_WATCHDOG_EN to enable the command watchdog.
//
// Ports:
//   CLOCK_50  - clock, all flops rising-edge
//   RESET     - asynchronous active-high reset; stops both wheels at once
//   cmd_valid - command offered; cmd_lwa / cmd_rwa: 1 = forward, 0 = stop
//   cmd_ready - high in IDLE and RUN
//   pwm_l/r   - motor PWM outputs
//   state     - FSM state (IDLE=0, RAMP=1, RUN=2)
//   wdog_trip - one-cycle pulse when the watchdog expires (0 when disabled)
module robbie_wheel_drive
  import robbie_pkg::*;
#(
  parameter int PWM_PERIOD       = 100,
  parameter int DUTY_MAX         = 100,
  parameter int RAMP_STEP_CYCLES = 1000,
  parameter int WDOG_CYCLES      = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       cmd_valid,
  input  logic       cmd_lwa,
  input  logic       cmd_rwa,
  output logic       cmd_ready,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic [1:0] state,
  output logic       wdog_trip
);

  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam int RW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;

  localparam logic [CW-1:0] DUTY_FULL   = CW'(DUTY_MAX);
  localparam logic [CW-1:0] FRAME_LAST  = CW'(PWM_PERIOD - 1);
  localparam logic [RW-1:0] RAMP_LAST   = RW'(RAMP_STEP_CYCLES - 1);

  generate
    if (DUTY_MAX > PWM_PERIOD || DUTY_MAX < 0 || PWM_PERIOD < 1 ||
        RAMP_STEP_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_bad_params
      $error("robbie_wheel_drive: illegal parameters (need 0 <= DUTY_MAX <= PWM_PERIOD)");
    end
  endgenerate

  state_t          st;
  logic [CW-1:0]   tgt_l, tgt_r;
  logic [CW-1:0]   duty_l, duty_r;
  logic [CW-1:0]   new_l, new_r;
  logic [CW-1:0]   frame_cnt;
  logic [RW-1:0]   ramp_cnt;
  logic            accept;
  logic            step;
  logic            st_bad;
  logic            wdog_expire;

  assign state     = st;
  assign cmd_ready = (st == IDLE) || (st == RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign new_l     = (cmd_lwa == WHEEL_FWD)  ? DUTY_FULL : '0;
  assign new_r     = (cmd_rwa == WHEEL_STOP) ? '0 : DUTY_FULL;
  assign step      = (st == RAMP) && (ramp_cnt == RAMP_LAST);
  assign st_bad    = (st != IDLE) && (st != RAMP) && (st != RUN);

  // Free-running PWM frame position shared by both wheels.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      frame_cnt <= '0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CW'(1);
    end
  end

  // Step timer: held at 0 outside RAMP so every ramp starts a full interval
  // after acceptance; a watchdog trip inside RAMP does not restart it.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      ramp_cnt <= '0;
    end else if (accept || st != RAMP || ramp_cnt == RAMP_LAST) begin
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= ramp_cnt + RW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      st    <= IDLE;
      tgt_l <= '0;
      tgt_r <= '0;
    end else begin
      case (st)
        IDLE, RUN: begin
          if (accept) begin
            tgt_l <= new_l;
            tgt_r <= new_r;
            if (new_l != duty_l || new_r != duty_r) begin
              st <= RAMP;
            end else if (new_l == '0 && new_r == '0) begin
              st <= IDLE;
            end else begin
              st <= RUN;
            end
          end else if (wdog_expire) begin
            tgt_l <= '0;
            tgt_r <= '0;
            st    <= RAMP;
          end
        end
        RAMP: begin
          if (wdog_expire) begin
            tgt_l <= '0;
            tgt_r <= '0;
          end else if (duty_l == tgt_l && duty_r == tgt_r) begin
            st <= (tgt_l == '0 && tgt_r == '0) ? IDLE : RUN;
          end
        end
        default: begin
          // 2'd3: wheels are cleared in the ramp blocks on this same edge
          st    <= IDLE;
          tgt_l <= '0;
          tgt_r <= '0;
        end
      endcase
    end
  end

`ifdef ROBBIE_WATCHDOG_EN
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_cnt;
  logic          wdog_q;

  // A command landing on the expiry cycle refreshes the timer instead of tripping.
  assign wdog_expire = (st == RAMP || st == RUN) && (wdog_cnt == WDOG_LAST) && !accept;
  assign wdog_trip   = wdog_q;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else begin
      wdog_q <= wdog_expire;
      if (accept || wdog_expire || !(st == RAMP || st == RUN)) begin
        wdog_cnt <= '0;
      end else begin
        wdog_cnt <= wdog_cnt + WW'(1);
      end
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign wdog_trip   = 1'b0;
`endif

  robbie_wheel_ramp #(.W(CW)) u_left (
    .clk       (CLOCK_50),
    .rst       (RESET),
    .frame_cnt (frame_cnt),
    .tgt       (tgt_l),
    .step      (step),
    .clear     (st_bad),
    .duty      (duty_l),
    .pwm       (pwm_l)
  );

  robbie_wheel_ramp #(.W(CW)) u_right (
    .clk       (CLOCK_50),
    .rst       (RESET),
    .frame_cnt (frame_cnt),
    .tgt       (tgt_r),
    .step      (step),
    .clear     (st_bad),
    .duty      (duty_r),
    .pwm       (pwm_r)
  );

endmodule
